// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential imem requests, queues in-order responses,
// and applies predictor/retire redirects while discarding wrong-path responses in flight.
module fetch_unit #(
  parameter int unsigned              ADDRESS_SIZE     = 64,
  parameter int unsigned              INSTRUCTION_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0]  RESET_PC         = '0,
  parameter int unsigned              QUEUE_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [ADDRESS_SIZE-1:0]     imem_req_addr,
  input  logic                        imem_resp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_resp_data,
  output logic [ADDRESS_SIZE-1:0]     pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic                        fetch_valid,
  input  logic                        frontend_stall,
  input  logic [ADDRESS_SIZE-1:0]     next_pc,
  input  logic                        overwrite_pc,
  input  logic                        flush,
  input  logic [ADDRESS_SIZE-1:0]     flush_pc
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [ADDRESS_SIZE-1:0] PC_STEP = ADDRESS_SIZE'(4);

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0]     pc;
    logic [INSTRUCTION_SIZE-1:0] instr;
  } entry_t;

  logic [ADDRESS_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_SIZE-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]        outstanding_q, outstanding_d;
  logic [CNT_W-1:0]        drop_count_q, drop_count_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  entry_t                  queue_q [QUEUE_DEPTH];
  entry_t                  queue_d [QUEUE_DEPTH];

  logic                    consume;
  logic                    pred_redirect;
  logic                    redirect;
  logic                    has_room;
  logic                    req_fire;
  logic                    push;
  logic [ADDRESS_SIZE-1:0] redirect_target;

  assign fetch_valid   = (count_q != '0);
  assign pc            = queue_q[head_q].pc;
  assign instruction   = queue_q[head_q].instr;
  assign imem_req_addr = fetch_pc_q;

  // Queued plus in-flight never exceeds the queue, so a push always has a free slot.
  assign consume        = fetch_valid && !frontend_stall;
  assign pred_redirect  = consume && overwrite_pc;
  assign redirect       = flush || pred_redirect;
  assign has_room       = (SUM_W'(count_q) + SUM_W'(outstanding_q)) < SUM_W'(QUEUE_DEPTH);
  assign imem_req_valid = reset && !redirect && has_room;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    resp_pc_d       = resp_pc_q;
    outstanding_d   = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
    drop_count_d    = drop_count_q;
    count_d         = count_q;
    head_d          = head_q;
    tail_d          = tail_q;
    queue_d         = queue_q;
    push            = 1'b0;
    redirect_target = flush ? flush_pc : next_pc;

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    if (redirect) begin
      // Everything still in flight is wrong-path, including a response landing this cycle.
      fetch_pc_d   = redirect_target;
      resp_pc_d    = redirect_target;
      drop_count_d = outstanding_q - CNT_W'(imem_resp_valid);
      count_d      = '0;
      head_d       = '0;
      tail_d       = '0;
    end else begin
      if (imem_resp_valid) begin
        if (drop_count_q != '0) begin
          drop_count_d = drop_count_q - CNT_W'(1);
        end else begin
          push = 1'b1;
        end
      end
      if (push) begin
        queue_d[tail_q] = '{pc: resp_pc_q, instr: imem_resp_data};
        tail_d          = tail_q + PTR_W'(1);
        resp_pc_d       = resp_pc_q + PC_STEP;
      end
      if (consume) begin
        head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(consume);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_count_q  <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        queue_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      queue_q       <= queue_d;
    end
  end

`ifndef SYNTHESIS
  // Memory may only answer requests it has accepted.
  resp_needs_request: assert property (@(posedge clk) disable iff (!reset)
    imem_resp_valid |-> (outstanding_q != '0))
    else $error("fetch_unit: imem response with no outstanding request");
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written redirect,
// back-pressure, latency, address-wrap and asynchronous-reset sequences.
module tb_fetch_unit;

  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic [AW-1:0] pc;
  logic [IW-1:0] instruction;
  logic          fetch_valid, frontend_stall, overwrite_pc, flush;
  logic [AW-1:0] next_pc, flush_pc;

  logic          rst_w_n;
  logic          w_req_valid, w_fetch_valid;
  logic [AW-1:0] w_req_addr, w_pc;
  logic [IW-1:0] w_instr;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .pc(pc), .instruction(instruction), .fetch_valid(fetch_valid),
    .frontend_stall(frontend_stall), .next_pc(next_pc), .overwrite_pc(overwrite_pc),
    .flush(flush), .flush_pc(flush_pc)
  );

  // Second instance only exercises fetch_pc wrap-around from the top of the address space.
  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(rst_w_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(w_req_addr),
    .imem_resp_valid(1'b0), .imem_resp_data(32'h0),
    .pc(w_pc), .instruction(w_instr), .fetch_valid(w_fetch_valid),
    .frontend_stall(1'b1), .next_pc(64'h0), .overwrite_pc(1'b0),
    .flush(1'b0), .flush_pc(64'h0)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            rdy;
  } mreq_t;

  typedef struct {
    logic          stall;
    logic          fl;
    logic          ovr;
    logic [AW-1:0] fpc;
    logic [AW-1:0] npc;
    logic          e_rv;
    logic [AW-1:0] e_addr;
    logic          e_fv;
    logic [AW-1:0] e_pc;
  } vec_t;

  mreq_t         memq[$];
  logic [AW-1:0] issued[$];
  vec_t          vt[21];
  int            lat = 1;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    return 32'h1300_0013 ^ a[31:0];
  endfunction

  function automatic vec_t mk(input logic st, input logic fl, input logic ov,
                              input logic [AW-1:0] fp, input logic [AW-1:0] np,
                              input logic rv, input logic [AW-1:0] ad,
                              input logic fv, input logic [AW-1:0] p);
    vec_t v;
    v.stall = st; v.fl = fl; v.ovr = ov; v.fpc = fp; v.npc = np;
    v.e_rv = rv; v.e_addr = ad; v.e_fv = fv; v.e_pc = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic present();
    if (memq.size() > 0 && memq[0].rdy <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(memq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
  endtask

  // One clock: capture the handshake before the edge, then advance the memory model.
  task automatic step();
    logic          fire;
    logic [AW-1:0] a;
    #1;
    fire = imem_req_valid && imem_req_ready;
    a    = imem_req_addr;
    @(posedge clk);
    cyc++;
    #1;
    if (imem_resp_valid) void'(memq.pop_front());
    if (fire) begin
      memq.push_back('{addr: a, rdy: cyc + lat - 1});
      issued.push_back(a);
    end
    present();
  endtask

  task automatic do_flush(input logic [AW-1:0] target);
    flush = 1'b1; flush_pc = target;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int            n_before;
    int            e_fire;
    int            e_fv;
    bit            seen400;
    bit            ok;

    //               st fl ov fpc      npc       rv addr      fv pc
    vt[0]  = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h0,   0, 64'h0);
    vt[1]  = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h4,   0, 64'h0);
    vt[2]  = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h8,   1, 64'h0);
    vt[3]  = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'hC,   1, 64'h0);
    vt[4]  = mk(1, 0, 0, 64'h0,   64'h0,   0, 64'h10,  1, 64'h0);
    vt[5]  = mk(0, 0, 0, 64'h0,   64'h0,   0, 64'h10,  1, 64'h0);
    vt[6]  = mk(0, 0, 0, 64'h0,   64'h0,   1, 64'h10,  1, 64'h4);
    vt[7]  = mk(0, 0, 1, 64'h0,   64'h100, 0, 64'h14,  1, 64'h8);
    vt[8]  = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h100, 0, 64'h0);
    vt[9]  = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h104, 0, 64'h0);
    vt[10] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h108, 1, 64'h100);
    vt[11] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h10C, 1, 64'h100);
    vt[12] = mk(1, 0, 0, 64'h0,   64'h0,   0, 64'h110, 1, 64'h100);
    vt[13] = mk(1, 1, 0, 64'h200, 64'h0,   0, 64'h110, 1, 64'h100);
    vt[14] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h200, 0, 64'h0);
    vt[15] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h204, 0, 64'h0);
    vt[16] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h208, 1, 64'h200);
    vt[17] = mk(0, 1, 1, 64'h300, 64'h400, 0, 64'h20C, 1, 64'h200);
    vt[18] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h300, 0, 64'h0);
    vt[19] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h304, 0, 64'h0);
    vt[20] = mk(1, 0, 0, 64'h0,   64'h0,   1, 64'h308, 1, 64'h300);

    reset = 1'b0; rst_w_n = 1'b0;
    imem_req_ready = 1'b1; frontend_stall = 1'b1;
    overwrite_pc = 1'b0; next_pc = '0; flush = 1'b0; flush_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'h0);
    chk("rst_req_addr", imem_req_addr, 64'h0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", 64'(instruction), 64'h0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      frontend_stall = vt[i].stall;
      flush          = vt[i].fl;
      flush_pc       = vt[i].fpc;
      overwrite_pc   = vt[i].ovr;
      next_pc        = vt[i].npc;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 64'(imem_req_valid), 64'(vt[i].e_rv));
      chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_fetch_valid", i), 64'(fetch_valid), 64'(vt[i].e_fv));
      if (vt[i].e_fv) begin
        chk($sformatf("vec%0d_pc", i), pc, vt[i].e_pc);
        chk($sformatf("vec%0d_instr", i), 64'(instruction), 64'(mem_data(vt[i].e_pc)));
      end
      step();
    end
    flush = 1'b0; overwrite_pc = 1'b0; frontend_stall = 1'b1;

    seen400 = 1'b0;
    foreach (issued[k]) if (issued[k] == 64'h400) seen400 = 1'b1;
    chk("never_req_0x400", 64'(seen400), 64'h0);

    // Back-pressure: address and valid held while ready is low.
    do_flush(64'h40);
    imem_req_ready = 1'b0;
    n_before = issued.size();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("hold%0d_valid", i), 64'(imem_req_valid), 64'h1);
      chk($sformatf("hold%0d_addr", i), imem_req_addr, 64'h40);
      step();
    end
    chk("hold_no_handshake", 64'(issued.size() - n_before), 64'h0);
    imem_req_ready = 1'b1;
    #1;
    chk("release_addr", imem_req_addr, 64'h40);
    step();
    chk("release_one_handshake", 64'(issued.size() - n_before), 64'h1);
    chk("release_handshake_addr", issued[issued.size()-1], 64'h40);
    #1;
    chk("after_release_addr", imem_req_addr, 64'h44);

    // Latency 3 with in-flight wrong-path responses to drop.
    lat = 3;
    do_flush(64'h500);
    repeat (5) step();
    chk("lat3_head_valid", 64'(fetch_valid), 64'h1);
    chk("lat3_head_pc", pc, 64'h500);
    do_flush(64'h600);
    e_fire = -1; e_fv = -1; ok = 1'b0;
    n_before = issued.size();
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (e_fire < 0 && issued.size() > n_before) e_fire = cyc;
      if (fetch_valid) begin
        e_fv = cyc;
        ok   = 1'b1;
      end
    end
    chk("drop_first_req", (issued.size() > n_before) ? issued[n_before] : 64'hDEAD, 64'h600);
    chk("drop_fv_seen", 64'(ok), 64'h1);
    chk("drop_latency", 64'(e_fv - e_fire), 64'(lat));
    chk("drop_head_pc", pc, 64'h600);
    chk("drop_head_instr", 64'(instruction), 64'(mem_data(64'h600)));

    // Fetch PC wraps modulo 2^64.
    lat = 1;
    rst_w_n = 1'b1;
    #1;
    chk("wrap_first_valid", 64'(w_req_valid), 64'h1);
    chk("wrap_first_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("wrap_second_addr", w_req_addr, 64'h0);
    step();
    chk("wrap_third_addr", w_req_addr, 64'h4);
    step();
    chk("wrap_fourth_addr", w_req_addr, 64'h8);
    step();
    chk("wrap_full_valid", 64'(w_req_valid), 64'h0);

    // Asynchronous reset mid-burst.
    do_flush(64'h700);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      #1;
      ok = fetch_valid && imem_req_valid;
    end
    chk("burst_active", 64'(ok), 64'h1);
    reset = 1'b0; rst_w_n = 1'b0;
    memq.delete();
    imem_resp_valid = 1'b0;
    #1;
    chk("async_rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("async_rst_fetch_valid", 64'(fetch_valid), 64'h0);
    chk("async_rst_addr", imem_req_addr, 64'h0);
    chk("async_rst_pc", pc, 64'h0);
    chk("async_rst_instr", 64'(instruction), 64'h0);
    chk("async_rst_wrap_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    chk("held_rst_req_valid", 64'(imem_req_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
